// File: rtl/cpu_seq_pkg.sv
//------------------------------------------------------------------------------
// cpu_seq_pkg: state encodings and default widths for the fetch sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cpu_seq_pkg;
  localparam logic [1:0] c_FETCH  = 2'b00;
  localparam logic [1:0] c_DECODE = 2'b01;
  localparam logic [1:0] c_EXEC   = 2'b10;
  localparam logic [1:0] c_HALT   = 2'b11;

  localparam int c_PC_W    = 16;
  localparam int c_INSTR_W = 32;
endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
//------------------------------------------------------------------------------
// fetch_sequencer_if: memory, execute-control and status signals of the sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_sequencer_if
  import cpu_seq_pkg::*;
#(
  parameter int PC_W    = c_PC_W,
  parameter int INSTR_W = c_INSTR_W
);
  logic               mem_req;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_ready;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] instr_out;
  logic               instr_valid;
  logic               exec_done;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               halt;
  logic [PC_W-1:0]    pc_out;
  logic [1:0]         state_out;
  logic               halted;
  logic               fetch_err;

  modport master (
    output mem_req, mem_addr, instr_out, instr_valid, pc_out, state_out, halted, fetch_err,
    input  mem_ready, mem_rdata, exec_done, branch_taken, branch_target, halt
  );

  modport slave (
    input  mem_req, mem_addr, instr_out, instr_valid, pc_out, state_out, halted, fetch_err,
    output mem_ready, mem_rdata, exec_done, branch_taken, branch_target, halt
  );
endinterface

`default_nettype wire

// File: rtl/fetch_watchdog.sv
//------------------------------------------------------------------------------
// fetch_watchdog: counts stalled FETCH cycles and trips at TIMEOUT_CYCLES.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic i_in_fetch,
  input  wire logic i_mem_ready,
  output wire logic o_trip,
  output wire logic o_fetch_err
);
  localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               r_fetch_err;
  logic               w_stall;

  assign w_stall     = i_in_fetch & ~i_mem_ready;
  // r_cnt holds the number of earlier stalled cycles, so the trip lands on the last one
  assign o_trip      = w_stall & (r_cnt == c_LIMIT);
  assign o_fetch_err = r_fetch_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if (!w_stall) begin
        r_cnt <= '0;
      end else if (!o_trip) begin
        r_cnt <= r_cnt + c_ONE;
      end
      if (o_trip) begin
        r_fetch_err <= 1'b1;
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
//------------------------------------------------------------------------------
// fetch_sequencer: FETCH/DECODE/EXEC/HALT instruction sequencer with branch support.
// Optional fetch watchdog under FETCH_SEQ_TIMEOUT_EN. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int          PC_W     = c_PC_W,
  parameter int          INSTR_W  = c_INSTR_W,
  parameter int unsigned RESET_PC = 0
`ifdef FETCH_SEQ_TIMEOUT_EN
  ,
  parameter int          TIMEOUT_CYCLES = 15
`endif
) (
  input wire logic           clk,
  input wire logic           reset,
  fetch_sequencer_if.master  bus
);
  localparam logic [PC_W-1:0] c_RESET_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] c_PC_ONE   = PC_W'(1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_instr_valid;
  logic               w_in_fetch;
  logic               w_trip;
  logic               w_fetch_err;
  logic               w_mem_req;
  logic               w_halted;

  assign w_in_fetch = (r_state == c_FETCH);

`ifdef FETCH_SEQ_TIMEOUT_EN
  fetch_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fetch_watchdog (
    .clk         (clk),
    .reset       (reset),
    .i_in_fetch  (w_in_fetch),
    .i_mem_ready (bus.mem_ready),
    .o_trip      (w_trip),
    .o_fetch_err (w_fetch_err)
  );
`else
  assign w_trip      = 1'b0;
  assign w_fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_FETCH: begin
        if (bus.mem_ready) begin
          w_next_state = c_DECODE;
        end else if (w_trip) begin
          w_next_state = c_HALT;
        end
      end
      c_DECODE: w_next_state = c_EXEC;
      c_EXEC: begin
        if (bus.exec_done) begin
          w_next_state = bus.halt ? c_HALT : c_FETCH;
        end
      end
      default: w_next_state = r_state;
    endcase
  end

  always_comb begin
    w_mem_req = (r_state == c_FETCH);
    w_halted  = (r_state == c_HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= c_RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_instr_valid <= (r_state == c_DECODE);
      if (w_in_fetch && bus.mem_ready) begin
        r_instr <= bus.mem_rdata;
      end
      // The increment wraps naturally at PC_W bits
      if ((r_state == c_EXEC) && bus.exec_done) begin
        r_pc <= bus.branch_taken ? bus.branch_target : (r_pc + c_PC_ONE);
      end
    end
  end

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_addr    = r_pc;
  assign bus.pc_out      = r_pc;
  assign bus.instr_out   = r_instr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.state_out   = r_state;
  assign bus.halted      = w_halted;
  assign bus.fetch_err   = w_fetch_err;
endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
//------------------------------------------------------------------------------
// tb_fetch_sequencer: directed stimulus against a cycle-level model of the sequencer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_sequencer;
  localparam int          PC_W    = 16;
  localparam int          INSTR_W = 32;
  localparam logic [15:0] RST_PC  = 16'h0010;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  fetch_sequencer_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) bus ();

  fetch_sequencer #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC (32'h0000_0010)
`ifdef FETCH_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (15)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: phase 0=fetch 1=decode 2=exec 3=halt
  int          m_phase = 0;
  logic [15:0] m_pc    = RST_PC;
  logic [31:0] m_instr = '0;
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  int          m_wait  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_pc = RST_PC; m_instr = '0; m_valid = 1'b0; m_err = 1'b0; m_wait = 0;
    end else begin
      m_valid = 1'b0;
      case (m_phase)
        0: begin
          if (bus.mem_ready) begin
            m_instr = bus.mem_rdata;
            m_phase = 1;
          end
`ifdef FETCH_SEQ_TIMEOUT_EN
          else begin
            m_wait++;
            if (m_wait == 15) begin
              m_err   = 1'b1;
              m_phase = 3;
            end
          end
`endif
        end
        1: begin
          m_phase = 2;
          m_valid = 1'b1;
        end
        2: begin
          if (bus.exec_done) begin
            m_pc    = bus.branch_taken ? bus.branch_target : 16'((32'(m_pc) + 1) % 65536);
            m_phase = bus.halt ? 3 : 0;
            m_wait  = 0;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("state_out",   64'(bus.state_out),   64'(m_phase));
    chk("pc_out",      64'(bus.pc_out),      64'(m_pc));
    chk("mem_addr",    64'(bus.mem_addr),    64'(m_pc));
    chk("mem_req",     64'(bus.mem_req),     64'(m_phase == 0));
    chk("instr_out",   64'(bus.instr_out),   64'(m_instr));
    chk("instr_valid", 64'(bus.instr_valid), 64'(m_valid));
    chk("halted",      64'(bus.halted),      64'(m_phase == 3));
    chk("fetch_err",   64'(bus.fetch_err),   64'(m_err));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.exec_done = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = '0; bus.halt = 1'b0;
    #1 reset = 1'b1;
    cyc(2);
    chk("rst_state", 64'(bus.state_out), 64'h0);
    chk("rst_instr", 64'(bus.instr_out), 64'h0);
    reset = 1'b0;
    chk("rst_addr", 64'(bus.mem_addr), 64'h0010);
    chk("rst_req",  64'(bus.mem_req),  64'h1);

    // back-to-back minimum-latency instructions
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hA5A5_0001; bus.exec_done = 1'b1;
    cyc(2);
    chk("t1_valid", 64'(bus.instr_valid), 64'h1);
    chk("t1_instr", 64'(bus.instr_out),   64'hA5A5_0001);
    cyc(1);
    chk("t1_addr1", 64'(bus.mem_addr), 64'h0011);
    cyc(2);
    chk("t1_valid2", 64'(bus.instr_valid), 64'h1);
    cyc(1);
    chk("t1_addr2", 64'(bus.mem_addr), 64'h0012);

    // delayed mem_ready and slow execute
    bus.mem_ready = 1'b0; bus.exec_done = 1'b0;
    cyc(4);
    chk("t2_req",  64'(bus.mem_req),  64'h1);
    chk("t2_addr", 64'(bus.mem_addr), 64'h0012);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
    cyc(1);
    chk("t2_decode", 64'(bus.state_out), 64'h1);
    chk("t2_instr",  64'(bus.instr_out), 64'h1234_5678);
    bus.mem_ready = 1'b0;
    cyc(3);
    chk("t2_exec", 64'(bus.state_out), 64'h2);
    chk("t2_pc",   64'(bus.pc_out),    64'h0012);

    // branch, then wrap from all-ones
    bus.exec_done = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 16'h0200;
    cyc(1);
    chk("t3_branch", 64'(bus.mem_addr), 64'h0200);
    bus.mem_ready = 1'b1; bus.branch_target = 16'hFFFF;
    cyc(3);
    chk("t3_ffff", 64'(bus.mem_addr), 64'hFFFF);
    bus.branch_taken = 1'b0;
    cyc(3);
    chk("t3_wrap", 64'(bus.mem_addr), 64'h0000);

    // halt at pc 5
    bus.branch_taken = 1'b1; bus.branch_target = 16'h0005;
    cyc(3);
    chk("t4_pc5", 64'(bus.pc_out), 64'h0005);
    bus.branch_taken = 1'b0; bus.halt = 1'b1;
    cyc(3);
    chk("t4_state",  64'(bus.state_out), 64'h3);
    chk("t4_halted", 64'(bus.halted),    64'h1);
    chk("t4_pc",     64'(bus.pc_out),    64'h0006);
    chk("t4_req",    64'(bus.mem_req),   64'h0);
    bus.branch_taken = 1'b1; bus.branch_target = 16'h0AAA; bus.exec_done = 1'b0;
    cyc(1);
    bus.exec_done = 1'b1;
    cyc(3);
    chk("t4_frozen_pc", 64'(bus.pc_out),    64'h0006);
    chk("t4_frozen_st", 64'(bus.state_out), 64'h3);

    // asynchronous reset, from HALT and mid-EXEC
    bus.halt = 1'b0; bus.branch_taken = 1'b0;
    reset = 1'b1;
    #1;
    chk("t5_halt_rst_state", 64'(bus.state_out), 64'h0);
    chk("t5_halt_rst_pc",    64'(bus.pc_out),    64'h0010);
    cyc(1);
    reset = 1'b0; bus.mem_ready = 1'b1; bus.exec_done = 1'b0; bus.mem_rdata = 32'hDEAD_BEEF;
    cyc(3);
    chk("t5_in_exec", 64'(bus.state_out), 64'h2);
    #1 reset = 1'b1;
    #1;
    chk("t5_rst_state", 64'(bus.state_out),   64'h0);
    chk("t5_rst_instr", 64'(bus.instr_out),   64'h0);
    chk("t5_rst_req",   64'(bus.mem_req),     64'h1);
    chk("t5_rst_valid", 64'(bus.instr_valid), 64'h0);
    cyc(1);
    reset = 1'b0; bus.exec_done = 1'b1;
    cyc(3);
    chk("t5_restart", 64'(bus.mem_addr), 64'h0011);

`ifdef FETCH_SEQ_TIMEOUT_EN
    // watchdog: trip after 15 stalled cycles, or complete on the 15th
    reset = 1'b1;
    cyc(1);
    reset = 1'b0; bus.mem_ready = 1'b0; bus.exec_done = 1'b0;
    cyc(14);
    chk("t6_pre_state", 64'(bus.state_out), 64'h0);
    chk("t6_pre_err",   64'(bus.fetch_err), 64'h0);
    cyc(1);
    chk("t6_trip_state", 64'(bus.state_out), 64'h3);
    chk("t6_trip_err",   64'(bus.fetch_err), 64'h1);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(14);
    bus.mem_ready = 1'b1;
    cyc(1);
    chk("t6_late_state", 64'(bus.state_out), 64'h1);
    chk("t6_late_err",   64'(bus.fetch_err), 64'h0);
`endif

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Parametrised instruction-sequencing controller for the CPU. It replaces the fixed three-state fetch/decode/execute loop with the following capabilities:
- a ready-handshaked memory fetch
- a variable-length execute phase
- branch/PC-load support
- a halt state

It drives the program counter to the memory access block, latches the fetched instruction, and presents it to the ALU, register bank and MAB.

Parameters:
PC_W, 16, program counter / fetch address width
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset (truncated to PC_W)
TIMEOUT_CYCLES, 15, fetch watchdog limit; used only when the optional feature is compiled in

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
mem_req  output  1  fetch request to RAM
mem_addr  output  PC_W  fetch address (equals pc_out)
mem_ready  input  1  RAM has valid mem_rdata this cycle
mem_rdata  input  INSTR_W  instruction word from RAM
instr_out  output  INSTR_W  latched current instruction
instr_valid  output  1  one-cycle pulse: new instruction enters execute
exec_done  input  1  execute phase finished (ALU/MAB)
branch_taken  input  1  qualifies branch_target at exec_done
branch_target  input  PC_W  next PC when branch_taken
halt  input  1  stop after the current instruction
pc_out  output  PC_W  program counter
state_out  output  2  current state, for debug
halted  output  1  high in HALT
fetch_err  output  1  watchdog tripped (tied 0 without the optional feature)

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-high.
- Reset values:
  - state = FETCH, pc_out = RESET_PC, instr_out = 0.
  - instr_valid = 0, halted = 0, fetch_err = 0.
  - mem_req = 1 as soon as reset deasserts (it is combinational from state).
- State encoding: FETCH = 2'b00, DECODE = 2'b01, EXEC = 2'b10, HALT = 2'b11.
- FETCH:
  - mem_req = 1, mem_addr = pc_out.
  - On the clk edge where mem_ready = 1: instr_out <= mem_rdata, go to DECODE.
  - Otherwise remain in FETCH. The PC is stable throughout.
- DECODE:
  - Lasts exactly one cycle; mem_req = 0.
  - Go to EXEC. instr_valid is registered and high during the first EXEC cycle only.
- EXEC:
  - Wait for exec_done; mem_req = 0.
  - On exec_done = 1:
    - pc_out <= branch_taken ? branch_target : pc_out + 1.
    - The increment is modulo 2^PC_W, so all-ones wraps to 0.
    - If halt = 1 in the same cycle, go to HALT; else go to FETCH.
  - exec_done may already be high in the first EXEC cycle.
- Minimum latency: 3 cycles per instruction (mem_ready and exec_done both immediate).
- HALT:
  - Terminal until reset. halted = 1, mem_req = 0, pc_out and instr_out frozen.
  - All inputs are ignored.
- Input sampling: halt, branch_taken and branch_target are sampled only in EXEC with exec_done. In any other state they have no effect.
- mem_ready outside FETCH is ignored.
- Reset mid-operation (including during a pending fetch or in HALT) forces the reset values immediately. No partial instruction is retained.
- state_out mirrors the state register.

Optional Feature:
Macro: FETCH_SEQ_TIMEOUT_EN
- With the macro:
  - A counter clears on entry to FETCH and increments each FETCH cycle without mem_ready.
  - When the counter reaches TIMEOUT_CYCLES without mem_ready, set fetch_err = 1 (sticky until reset) and go to HALT.
  - mem_ready on the same edge as the limit wins: the fetch completes and there is no error.
- Without the macro: no counter is built, fetch_err is tied 0, and FETCH waits indefinitely.

Decomposition:
- Package cpu_seq_pkg holds:
  - the state encodings FETCH/DECODE/EXEC/HALT as 2-bit localparams
  - the default PC_W and INSTR_W
- One natural sub-module: fetch_watchdog. It holds the counter plus the trip compare and is instantiated only under FETCH_SEQ_TIMEOUT_EN.

Test Plan:
1. Reset with RESET_PC = 16'h0010, then mem_ready tied 1, mem_rdata = 32'hA5A5_0001, exec_done tied 1.
   -> mem_addr = 0x0010, 0x0011, 0x0012 every 3 cycles; instr_valid pulses every 3rd cycle; instr_out = 32'hA5A5_0001.
2. mem_ready delayed 4 cycles in FETCH.
   -> mem_req held high, mem_addr stable for 5 cycles, then DECODE. The PC is unchanged until exec_done.
3. exec_done with branch_taken = 1, branch_target = 16'h0200.
   -> the next mem_addr is 0x0200. With branch_taken = 0 and pc = 16'hFFFF, the next mem_addr wraps to 0x0000.
4. exec_done and halt both asserted at pc = 0x0005.
   -> state_out = 2'b11, halted = 1, pc_out = 0x0006, mem_req = 0. Later mem_ready/exec_done pulses cause no change.
5. Reset asserted asynchronously mid-EXEC, between clock edges.
   -> outputs take their reset values immediately, before the next clk edge; FETCH restarts at RESET_PC.
6. With FETCH_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES = 15, mem_ready held 0.
   -> fetch_err = 1 and HALT after 15 FETCH cycles. A separate run with mem_ready on cycle 15 -> no error, normal DECODE.
